// File: rtl/pipe_hazard_pkg.sv
// Shared pipeline hazard encodings, MDU latency defaults and the Tuse/Tnew
// dependency check used by the stall controller.
package pipe_hazard_pkg;

  localparam logic [1:0] TUSE_NONE       = 2'd3;
  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MULT_CYCLES_DEF = 5;
  localparam int         DIV_CYCLES_DEF  = 10;

  // A producer blocks a consumer when its result arrives later than the operand is needed.
  function automatic logic raw_stall(input logic [4:0] src,
                                     input logic [1:0] tuse,
                                     input logic [4:0] dst,
                                     input logic       we,
                                     input logic [1:0] tnew);
    return (src != REG_ZERO) && (tuse != TUSE_NONE) && we &&
           (dst == src) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-controller bundle: D/E/M hazard inputs, MDU start pulses and the
// stall outputs. The pipeline is the master, the controller the slave.
interface hazard_stall_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0]        rs_D;
  logic [4:0]        rt_D;
  logic [1:0]        tuse_rs_D;
  logic [1:0]        tuse_rt_D;
  logic              md_D;
  logic [4:0]        a3_E;
  logic [4:0]        a3_M;
  logic              we_E;
  logic              we_M;
  logic [1:0]        tnew_E;
  logic [1:0]        tnew_M;
  logic              start_mult;
  logic              start_div;
  logic              en_PC;
  logic              en_FD;
  logic              flush_DE;
  logic              mdu_busy;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
    output a3_E, a3_M, we_E, we_M, tnew_E, tnew_M,
    output start_mult, start_div,
    input  en_PC, en_FD, flush_DE, mdu_busy, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
    input  a3_E, a3_M, we_E, we_M, tnew_E, tnew_M,
    input  start_mult, start_div,
    output en_PC, en_FD, flush_DE, mdu_busy, stall_cnt
  );

endinterface

// File: rtl/mdu_busy_timer.sv
// Multiply/divide busy window: a down-counter loaded on each start pulse,
// busy while counting or while a start pulse is present.
module mdu_busy_timer
  import pipe_hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  output logic mdu_busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Divide wins over multiply; any start reloads, even mid-countdown.
  always_comb begin
    cnt_d = cnt_q;
    if (start_div) begin
      cnt_d = CNT_W'(DIV_CYCLES);
    end else if (start_mult) begin
      cnt_d = CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mdu_busy = start_mult | start_div | (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: Tuse/Tnew data hazards against E and M,
// MDU busy stalls, and a saturating stalled-cycle counter.
module hazard_stall_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz
);

  logic              data_stall;
  logic              mdu_stall;
  logic              stall;
  logic              mdu_busy;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;

  mdu_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_mdu_busy_timer (
    .clk        (clk),
    .reset      (reset),
    .start_mult (hz.start_mult),
    .start_div  (hz.start_div),
    .mdu_busy   (mdu_busy)
  );

  assign data_stall =
      raw_stall(hz.rs_D, hz.tuse_rs_D, hz.a3_E, hz.we_E, hz.tnew_E) |
      raw_stall(hz.rs_D, hz.tuse_rs_D, hz.a3_M, hz.we_M, hz.tnew_M) |
      raw_stall(hz.rt_D, hz.tuse_rt_D, hz.a3_E, hz.we_E, hz.tnew_E) |
      raw_stall(hz.rt_D, hz.tuse_rt_D, hz.a3_M, hz.we_M, hz.tnew_M);

  assign mdu_stall = hz.md_D & mdu_busy;
  assign stall     = data_stall | mdu_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.en_PC     = ~stall;
  assign hz.en_FD     = ~stall;
  assign hz.flush_DE  = stall;
  assign hz.mdu_busy  = mdu_busy;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a cycle-indexed reference model
// queues expected outputs, a negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       md;
    logic [4:0] a3_e, a3_m;
    logic       we_e, we_m;
    logic [1:0] tnew_e, tnew_m;
    logic       smul, sdiv;
    logic       rst;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        en_pc, en_fd, flush, busy;
    logic [31:0] cnt;
    logic [3:0]  cnt_small;
  } exp_t;

  logic clk;
  logic reset;

  hazard_stall_ctrl_if #(.PERF_W(32)) hz ();
  hazard_stall_ctrl_if #(.PERF_W(4))  hz_s ();

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4), .PERF_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4), .PERF_W(4)) u_dut_small (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_s)
  );

  exp_t    exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  int      busy_until = -1;
  longint  count    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t idle();
    stim_t s;
    s.rs = 5'd0; s.rt = 5'd0; s.tuse_rs = 2'd3; s.tuse_rt = 2'd3; s.md = 1'b0;
    s.a3_e = 5'd0; s.a3_m = 5'd0; s.we_e = 1'b0; s.we_m = 1'b0;
    s.tnew_e = 2'd0; s.tnew_m = 2'd0; s.smul = 1'b0; s.sdiv = 1'b0; s.rst = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    hz.rs_D = s.rs;           hz_s.rs_D = s.rs;
    hz.rt_D = s.rt;           hz_s.rt_D = s.rt;
    hz.tuse_rs_D = s.tuse_rs; hz_s.tuse_rs_D = s.tuse_rs;
    hz.tuse_rt_D = s.tuse_rt; hz_s.tuse_rt_D = s.tuse_rt;
    hz.md_D = s.md;           hz_s.md_D = s.md;
    hz.a3_E = s.a3_e;         hz_s.a3_E = s.a3_e;
    hz.a3_M = s.a3_m;         hz_s.a3_M = s.a3_m;
    hz.we_E = s.we_e;         hz_s.we_E = s.we_e;
    hz.we_M = s.we_m;         hz_s.we_M = s.we_m;
    hz.tnew_E = s.tnew_e;     hz_s.tnew_E = s.tnew_e;
    hz.tnew_M = s.tnew_m;     hz_s.tnew_M = s.tnew_m;
    hz.start_mult = s.smul;   hz_s.start_mult = s.smul;
    hz.start_div = s.sdiv;    hz_s.start_div = s.sdiv;
    reset = s.rst;
  endtask

  // Reference model: busy is "current cycle within the last start's window",
  // the counter is a plain tally of stalled cycles clamped at the width limit.
  task automatic step(input stim_t s);
    exp_t e;
    logic stall;
    logic busy;
    logic [4:0] src [2];
    logic [1:0] tu  [2];
    @(posedge clk);
    #1;
    apply(s);
    cyc++;
    if (!s.rst) begin
      busy_until = -1;
      count      = 0;
    end
    busy = s.smul | s.sdiv | (cyc <= busy_until);
    src[0] = s.rs; tu[0] = s.tuse_rs;
    src[1] = s.rt; tu[1] = s.tuse_rt;
    stall = s.md & busy;
    for (int k = 0; k < 2; k++) begin
      if (src[k] != 5'd0) begin
        if (s.we_e && s.a3_e == src[k] && int'(tu[k]) < int'(s.tnew_e)) stall = 1'b1;
        if (s.we_m && s.a3_m == src[k] && int'(tu[k]) < int'(s.tnew_m)) stall = 1'b1;
      end
    end
    e.cyc       = cyc;
    e.en_pc     = ~stall;
    e.en_fd     = ~stall;
    e.flush     = stall;
    e.busy      = busy;
    e.cnt       = (count > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : count[31:0];
    e.cnt_small = (count > 15) ? 4'd15 : count[3:0];
    exp_q.push_back(e);
    if (s.rst) begin
      if (s.sdiv)      busy_until = cyc + DIV_N;
      else if (s.smul) busy_until = cyc + MULT_N;
      if (stall) count++;
    end
  endtask

  task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("en_PC",     e.cyc, 64'(hz.en_PC),       64'(e.en_pc));
        check("en_FD",     e.cyc, 64'(hz.en_FD),       64'(e.en_fd));
        check("flush_DE",  e.cyc, 64'(hz.flush_DE),    64'(e.flush));
        check("mdu_busy",  e.cyc, 64'(hz.mdu_busy),    64'(e.busy));
        check("stall_cnt", e.cyc, 64'(hz.stall_cnt),   64'(e.cnt));
        check("stall_cnt4", e.cyc, 64'(hz_s.stall_cnt), 64'(e.cnt_small));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    reset = 1'b0;
    s = idle(); s.rst = 1'b0;
    repeat (3) step(s);

    // load-use: E producer, then same producer in M, then ready
    s = idle(); s.rs = 5'd5; s.tuse_rs = 2'd0; s.a3_e = 5'd5; s.we_e = 1'b1; s.tnew_e = 2'd2;
    step(s);
    s = idle(); s.rs = 5'd5; s.tuse_rs = 2'd0; s.a3_m = 5'd5; s.we_m = 1'b1; s.tnew_m = 2'd1;
    step(s);
    s.tnew_m = 2'd0;
    step(s);

    // register zero never stalls
    s = idle(); s.tuse_rs = 2'd0; s.we_e = 1'b1; s.tnew_e = 2'd2;
    step(s);

    // mult window with md held
    s = idle(); s.md = 1'b1; s.smul = 1'b1;
    step(s);
    s.smul = 1'b0;
    repeat (7) step(s);

    // simultaneous starts: div wins
    s.smul = 1'b1; s.sdiv = 1'b1;
    step(s);
    s.smul = 1'b0; s.sdiv = 1'b0;
    repeat (12) step(s);

    // div restarted by mult at t+3
    s.sdiv = 1'b1;
    step(s);
    s.sdiv = 1'b0;
    repeat (2) step(s);
    s.smul = 1'b1;
    step(s);
    s.smul = 1'b0;
    repeat (8) step(s);

    // reset at t+2 of a div
    s.sdiv = 1'b1;
    step(s);
    s.sdiv = 1'b0;
    step(s);
    s.rst = 1'b0;
    repeat (2) step(s);
    s.rst = 1'b1;
    repeat (2) step(s);

    // held stall for saturation of the narrow counter
    s = idle(); s.rt = 5'd9; s.tuse_rt = 2'd1; s.a3_m = 5'd9; s.we_m = 1'b1; s.tnew_m = 2'd2;
    repeat (20) step(s);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.tuse_rs = 2'($urandom_range(0, 3));
      s.tuse_rt = 2'($urandom_range(0, 3));
      s.md      = ($urandom_range(0, 2) == 0);
      s.a3_e    = 5'($urandom_range(0, 3));
      s.a3_m    = 5'($urandom_range(0, 3));
      s.we_e    = 1'($urandom_range(0, 1));
      s.we_m    = 1'($urandom_range(0, 1));
      s.tnew_e  = 2'($urandom_range(0, 3));
      s.tnew_m  = 2'($urandom_range(0, 3));
      s.smul    = ($urandom_range(0, 15) == 0);
      s.sdiv    = ($urandom_range(0, 19) == 0);
      s.rst     = ($urandom_range(0, 99) != 0);
      step(s);
    end

    s = idle();
    step(s);
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", cyc, 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
